serial_ch_dispatcher: RTL and testbench
=======================================

// Module: serial_ch_dispatcher
// PURPOSE
//   Routes decoded command packets from the UART decoder to CH_NUM serial_out channels by i_sel_out.
//   Holds each channel's pattern/config, issues one-cycle start pulses, tracks busy via channel done ticks.
//   Provides a one-deep pending slot per channel so a command arriving mid-run is not lost.
//   Sits between decoder and the serial_out instances in diff_freq_serial_out top.
// PARAMETERS
//   DATA_BIT  32  width of output/frequency pattern per channel
//   CH_NUM    4   number of serial_out channels (1..15)
//   SEL_BIT   4   width of channel select field
// PORTS
//   clk                  in   1                 clock
//   rst_n                in   1                 reset, asynchronous, active-low
//   i_valid              in   1                 decoder done tick; command fields valid this cycle only
//   i_output_pattern     in   DATA_BIT          output pattern
//   i_freq_pattern       in   DATA_BIT          frequency pattern
//   i_sel_out            in   SEL_BIT           target channel
//   i_start              in   1                 command requests a run
//   i_stop               in   1                 command requests stop
//   i_mode               in   1                 0 one-shot, 1 repeat
//   i_ch_done_tick       in   CH_NUM            per-channel serial_out done tick
//   o_ch_start           out  CH_NUM            per-channel one-cycle start pulse
//   o_ch_stop            out  CH_NUM            per-channel stop level
//   o_ch_mode            out  CH_NUM            per-channel mode
//   o_ch_output_pattern  out  CH_NUM*DATA_BIT   channel n at [n*DATA_BIT +: DATA_BIT]
//   o_ch_freq_pattern    out  CH_NUM*DATA_BIT   same packing
//   o_ch_busy            out  CH_NUM            channel running
//   o_update_done_tick   out  1                 one-cycle pulse when a command is accepted
//   o_err_tick           out  1                 one-cycle pulse when a command is dropped
// BEHAVIOUR
//   Reset: all outputs 0, all channels IDLE, all pending slots empty.
//   Per-channel FSM: IDLE -> RUN on start issue; RUN -> IDLE on i_ch_done_tick[n] (one-shot) or stop.
//   Accept: i_valid at cycle T with sel<CH_NUM -> o_update_done_tick high cycle T+1.
//   start=1, channel IDLE: patterns/mode registered at T edge; o_ch_start[n] high cycle T+1 only;
//     o_ch_busy[n] high from T+1; o_ch_stop[n] cleared.
//   start=1, channel RUN, pending empty: store in pending; on i_ch_done_tick[n] at cycle D,
//     load pending, o_ch_start[n] pulses cycle D+1, busy stays high, pending cleared.
//   start=1, channel RUN, pending full: drop command, o_err_tick T+1, state unchanged.
//   done_tick and new start for same idle-bound channel same cycle, pending empty: treat as IDLE start.
//   stop=1 (takes priority over start): o_ch_stop[n] high from T+1 until next accepted start;
//     pending cleared; busy cleared T+1; FSM -> IDLE.
//   start=0, stop=0: update mode only, no pulse; still acknowledged.
//   Repeat mode: done ticks do not clear busy; only stop ends the run; pending loaded on next done tick.
//   sel>=CH_NUM (and not broadcast, see below): drop, o_err_tick T+1.
//   Pattern outputs held stable between loads; never change while o_ch_start low unless loading.
//   Done tick on an IDLE channel: ignored.
//   Async reset mid-run: all channels IDLE, pending lost, outputs 0 immediately.
// CONFIGURATION
//   SERIAL_SYNC_START_EN defined: sel = all-ones is broadcast; loads all channels; IDLE channels
//     receive simultaneous start in T+1; RUN channels follow per-channel pending rules.
//   Not defined: sel = all-ones treated as out of range -> dropped, o_err_tick.
// TESTING
//   Reset then idle 10 cycles -> all outputs 0, no ticks.
//   valid sel=0 start=1 out=0xA5A5A5A5 freq=0x0000FFFF -> start[0] 1 cycle at T+1, busy[0]=1, pattern held.
//   ch1 RUN, send cmd B, then cmd C -> B pending, C dropped with err_tick; done[1] -> start[1] next cycle with B.
//   ch2 repeat running, done[2] x3 -> busy stays 1; stop cmd -> stop[2]=1, busy[2]=0 at T+1.
//   sel=7 with CH_NUM=4 -> err_tick, no start, no update_done_tick.
//   SERIAL_SYNC_START_EN, sel=0xF, all IDLE -> o_ch_start=4'b1111 same cycle; undefined -> err_tick.

Source files
------------

// File: rtl/serial_ch_dispatcher_if.sv
// Command/channel bus between the UART decoder side and serial_ch_dispatcher.
// master drives commands and done ticks; slave is the dispatcher.
interface serial_ch_dispatcher_if #(
   parameter int DATA_BIT = 32,
   parameter int CH_NUM   = 4,
   parameter int SEL_BIT  = 4
);
   logic                         i_valid;
   logic [DATA_BIT-1:0]          i_output_pattern;
   logic [DATA_BIT-1:0]          i_freq_pattern;
   logic [SEL_BIT-1:0]           i_sel_out;
   logic                         i_start;
   logic                         i_stop;
   logic                         i_mode;
   logic [CH_NUM-1:0]            i_ch_done_tick;
   logic [CH_NUM-1:0]            o_ch_start;
   logic [CH_NUM-1:0]            o_ch_stop;
   logic [CH_NUM-1:0]            o_ch_mode;
   logic [CH_NUM*DATA_BIT-1:0]   o_ch_output_pattern;
   logic [CH_NUM*DATA_BIT-1:0]   o_ch_freq_pattern;
   logic [CH_NUM-1:0]            o_ch_busy;
   logic                         o_update_done_tick;
   logic                         o_err_tick;

   modport master (
      output i_valid, i_output_pattern, i_freq_pattern, i_sel_out, i_start, i_stop, i_mode,
             i_ch_done_tick,
      input  o_ch_start, o_ch_stop, o_ch_mode, o_ch_output_pattern, o_ch_freq_pattern,
             o_ch_busy, o_update_done_tick, o_err_tick
   );
   modport slave (
      input  i_valid, i_output_pattern, i_freq_pattern, i_sel_out, i_start, i_stop, i_mode,
             i_ch_done_tick,
      output o_ch_start, o_ch_stop, o_ch_mode, o_ch_output_pattern, o_ch_freq_pattern,
             o_ch_busy, o_update_done_tick, o_err_tick
   );
endinterface

// File: rtl/serial_ch_dispatcher.sv
// Routes decoded commands to CH_NUM serial_out channels, with a one-deep pending slot per channel.
// Optional SERIAL_SYNC_START_EN: sel = all-ones broadcasts the command to every channel.
module serial_ch_dispatcher #(
   parameter int DATA_BIT = 32,
   parameter int CH_NUM   = 4,
   parameter int SEL_BIT  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_ch_dispatcher_if.slave bus
);
   logic [SEL_BIT-1:0] sel;
   logic               bcast, in_range;
   logic [CH_NUM-1:0]  hit, drop;
   logic               upd_q, upd_d, err_q, err_d;

   assign sel = bus.i_sel_out;
`ifdef SERIAL_SYNC_START_EN
   assign bcast = (sel == {SEL_BIT{1'b1}});
`else
   assign bcast = 1'b0;
`endif
   assign in_range = (int'(sel) < CH_NUM) || bcast;

   for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
      typedef enum logic {IDLE, RUN} st_e;
      st_e                 st_q, st_d;
      logic                start_q, stop_q, mode_q, busy_c, done, drop_c;
      logic [DATA_BIT-1:0] out_q, freq_q, pout_q, pfreq_q;
      logic                pmode_q, pend_q;
      logic                ld_cmd, ld_pend, st_pend, clr_pend, set_stop, upd_mode;

      assign hit[n] = bus.i_valid && ((int'(sel) == n) || bcast);
      assign done   = bus.i_ch_done_tick[n] && (st_q == RUN);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) st_q <= IDLE;
         else        st_q <= st_d;
      end

      // Done tick is resolved first; a command hitting the same cycle may override it.
      always_comb begin
         st_d     = st_q;
         ld_cmd   = 1'b0;
         ld_pend  = 1'b0;
         st_pend  = 1'b0;
         clr_pend = 1'b0;
         set_stop = 1'b0;
         upd_mode = 1'b0;
         drop_c   = 1'b0;
         if (done) begin
            if (pend_q)       begin ld_pend = 1'b1; clr_pend = 1'b1; end
            else if (!mode_q) st_d = IDLE;
         end
         if (hit[n]) begin
            if (bus.i_stop) begin
               st_d     = IDLE;
               set_stop = 1'b1;
               clr_pend = 1'b1;
               ld_pend  = 1'b0;
            end else if (bus.i_start) begin
               if (st_q == IDLE || (done && !pend_q && !mode_q)) begin
                  ld_cmd = 1'b1;
                  st_d   = RUN;
               end else if (!pend_q) st_pend = 1'b1;
               else                  drop_c  = 1'b1;
            end else upd_mode = 1'b1;
         end
      end

      always_comb begin
         busy_c = (st_q == RUN);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            mode_q  <= 1'b0;
            out_q   <= '0;
            freq_q  <= '0;
            pend_q  <= 1'b0;
            pout_q  <= '0;
            pfreq_q <= '0;
            pmode_q <= 1'b0;
         end else begin
            start_q <= ld_cmd | ld_pend;
            if (ld_cmd) begin
               out_q  <= bus.i_output_pattern;
               freq_q <= bus.i_freq_pattern;
               mode_q <= bus.i_mode;
            end else if (ld_pend) begin
               out_q  <= pout_q;
               freq_q <= pfreq_q;
               mode_q <= pmode_q;
            end else if (upd_mode) begin
               mode_q <= bus.i_mode;
            end
            if (set_stop)    stop_q <= 1'b1;
            else if (ld_cmd) stop_q <= 1'b0;
            if (clr_pend) pend_q <= 1'b0;
            if (st_pend) begin
               pend_q  <= 1'b1;
               pout_q  <= bus.i_output_pattern;
               pfreq_q <= bus.i_freq_pattern;
               pmode_q <= bus.i_mode;
            end
         end
      end

      assign drop[n]                                           = drop_c;
      assign bus.o_ch_start[n]                                 = start_q;
      assign bus.o_ch_stop[n]                                  = stop_q;
      assign bus.o_ch_mode[n]                                  = mode_q;
      assign bus.o_ch_busy[n]                                  = busy_c;
      assign bus.o_ch_output_pattern[n*DATA_BIT +: DATA_BIT]   = out_q;
      assign bus.o_ch_freq_pattern[n*DATA_BIT +: DATA_BIT]     = freq_q;
   end

   // A partially dropped broadcast acknowledges the loaded channels and flags the rest.
   assign upd_d = in_range && |(hit & ~drop);
   assign err_d = (bus.i_valid && !in_range) || |drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         upd_q <= upd_d;
         err_q <= err_d;
      end
   end

   assign bus.o_update_done_tick = upd_q;
   assign bus.o_err_tick         = err_q;
endmodule

// File: tb/tb_serial_ch_dispatcher.sv
// Directed, table-driven bench for serial_ch_dispatcher (CH_NUM=4, DATA_BIT=32).
module tb_serial_ch_dispatcher;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   serial_ch_dispatcher_if #(.DATA_BIT(32), .CH_NUM(4), .SEL_BIT(4)) bus ();
   serial_ch_dispatcher #(.DATA_BIT(32), .CH_NUM(4), .SEL_BIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      logic v; logic [3:0] sel; logic st, sp, md; logic [31:0] op, fp; logic [3:0] dn;
      logic [3:0] e_start, e_busy, e_stop, e_mode; logic e_upd, e_err;
      int ch; logic [31:0] e_op, e_fp;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(logic v, logic [3:0] sel, logic st, logic sp, logic md,
                               logic [31:0] op, logic [31:0] fp, logic [3:0] dn,
                               logic [3:0] es, logic [3:0] eb, logic [3:0] esp, logic [3:0] em,
                               logic eu, logic ee, int ch, logic [31:0] eop, logic [31:0] efp);
      vec_t r;
      r.v = v; r.sel = sel; r.st = st; r.sp = sp; r.md = md; r.op = op; r.fp = fp; r.dn = dn;
      r.e_start = es; r.e_busy = eb; r.e_stop = esp; r.e_mode = em; r.e_upd = eu; r.e_err = ee;
      r.ch = ch; r.e_op = eop; r.e_fp = efp;
      return r;
   endfunction

   task automatic drive(logic v, logic [3:0] sel, logic st, logic sp, logic md,
                        logic [31:0] op, logic [31:0] fp, logic [3:0] dn);
      bus.i_valid = v; bus.i_sel_out = sel; bus.i_start = st; bus.i_stop = sp; bus.i_mode = md;
      bus.i_output_pattern = op; bus.i_freq_pattern = fp; bus.i_ch_done_tick = dn;
   endtask

   task automatic idle_in();
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] ctrl();
      return {bus.o_ch_start, bus.o_ch_busy, bus.o_ch_stop, bus.o_ch_mode,
              bus.o_update_done_tick, bus.o_err_tick};
   endfunction

   function automatic logic [31:0] opat(int ch);
      return bus.o_ch_output_pattern[ch*32 +: 32];
   endfunction

   function automatic logic [31:0] fpat(int ch);
      return bus.o_ch_freq_pattern[ch*32 +: 32];
   endfunction

   task automatic do_reset();
      idle_in();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      //            v  sel st sp md op            fp            dn    es   eb   esp  em   eu ee ch eop           efp
      tbl[0]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0, 4'h0,4'h0,4'h0,4'h0,0,0, 0, 32'h0,        32'h0);
      tbl[1]  = mk(1, 0, 1, 0, 0, 32'hA5A5A5A5, 32'h0000FFFF, 4'h0, 4'h1,4'h1,4'h0,4'h0,1,0, 0, 32'hA5A5A5A5, 32'h0000FFFF);
      tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0, 4'h0,4'h1,4'h0,4'h0,0,0, 0, 32'hA5A5A5A5, 32'h0000FFFF);
      tbl[3]  = mk(1, 1, 1, 0, 0, 32'h11111111, 32'h1,        4'h0, 4'h2,4'h3,4'h0,4'h0,1,0, 1, 32'h11111111, 32'h1);
      tbl[4]  = mk(1, 1, 1, 0, 0, 32'h22222222, 32'h2,        4'h0, 4'h0,4'h3,4'h0,4'h0,1,0, 1, 32'h11111111, 32'h1);
      tbl[5]  = mk(1, 1, 1, 0, 0, 32'h33333333, 32'h3,        4'h0, 4'h0,4'h3,4'h0,4'h0,0,1, 1, 32'h11111111, 32'h1);
      tbl[6]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h2, 4'h2,4'h3,4'h0,4'h0,0,0, 1, 32'h22222222, 32'h2);
      tbl[7]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h2, 4'h0,4'h1,4'h0,4'h0,0,0, 1, 32'h22222222, 32'h2);
      tbl[8]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h1, 4'h0,4'h0,4'h0,4'h0,0,0, 0, 32'hA5A5A5A5, 32'h0000FFFF);
      tbl[9]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h4, 4'h0,4'h0,4'h0,4'h0,0,0, 2, 32'h0,        32'h0);
      tbl[10] = mk(1, 2, 1, 0, 1, 32'h44444444, 32'h4,        4'h0, 4'h4,4'h4,4'h0,4'h4,1,0, 2, 32'h44444444, 32'h4);
      tbl[11] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h4, 4'h0,4'h4,4'h0,4'h4,0,0, 2, 32'h44444444, 32'h4);
      tbl[12] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h4, 4'h0,4'h4,4'h0,4'h4,0,0, 2, 32'h44444444, 32'h4);
      tbl[13] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h4, 4'h0,4'h4,4'h0,4'h4,0,0, 2, 32'h44444444, 32'h4);
      tbl[14] = mk(1, 2, 1, 1, 0, 32'hDEADBEEF, 32'hE,        4'h0, 4'h0,4'h0,4'h4,4'h4,1,0, 2, 32'h44444444, 32'h4);
      tbl[15] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0, 4'h0,4'h0,4'h4,4'h4,0,0, 2, 32'h44444444, 32'h4);
      tbl[16] = mk(1, 3, 1, 0, 0, 32'h66666666, 32'h6,        4'h0, 4'h8,4'h8,4'h4,4'h4,1,0, 3, 32'h66666666, 32'h6);
      tbl[17] = mk(1, 3, 1, 0, 0, 32'h77777777, 32'h7,        4'h8, 4'h8,4'h8,4'h4,4'h4,1,0, 3, 32'h77777777, 32'h7);
      tbl[18] = mk(1, 3, 0, 0, 1, 32'h99999999, 32'h9,        4'h0, 4'h0,4'h8,4'h4,4'hC,1,0, 3, 32'h77777777, 32'h7);
      tbl[19] = mk(1, 7, 1, 0, 0, 32'hBBBBBBBB, 32'hB,        4'h0, 4'h0,4'h8,4'h4,4'hC,0,1, 3, 32'h77777777, 32'h7);
      tbl[20] = mk(1, 2, 1, 0, 0, 32'h88888888, 32'h8,        4'h0, 4'h4,4'hC,4'h0,4'h8,1,0, 2, 32'h88888888, 32'h8);
`ifdef SERIAL_SYNC_START_EN
      tbl[21] = mk(1, 15,1, 0, 0, 32'h55555555, 32'h5,        4'h0, 4'h3,4'hF,4'h0,4'h8,1,0, 0, 32'h55555555, 32'h5);
`else
      tbl[21] = mk(1, 15,1, 0, 0, 32'h55555555, 32'h5,        4'h0, 4'h0,4'hC,4'h0,4'h8,0,1, 0, 32'hA5A5A5A5, 32'h0000FFFF);
`endif

      rst_n = 1'b1;
      idle_in();
      do_reset();

      // Quiet after reset: nothing moves for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         step();
         chk("reset_idle_ctrl", {46'h0, ctrl()}, 64'h0);
         chk("reset_idle_pat", {bus.o_ch_output_pattern[63:0]}, 64'h0);
      end

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].v, tbl[i].sel, tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].op, tbl[i].fp, tbl[i].dn);
         step();
         idle_in();
         chk($sformatf("row%0d_ctrl", i), {46'h0, ctrl()},
             {46'h0, tbl[i].e_start, tbl[i].e_busy, tbl[i].e_stop, tbl[i].e_mode,
              tbl[i].e_upd, tbl[i].e_err});
         chk($sformatf("row%0d_opat", i), {32'h0, opat(tbl[i].ch)}, {32'h0, tbl[i].e_op});
         chk($sformatf("row%0d_fpat", i), {32'h0, fpat(tbl[i].ch)}, {32'h0, tbl[i].e_fp});
      end

      // Repeat mode: pending loads on a done tick; stop discards a later pending command.
      do_reset();
      drive(1, 0, 1, 0, 1, 32'hCAFE0001, 32'h1, 4'h0); step();
      drive(1, 0, 1, 0, 1, 32'hCAFE0002, 32'h2, 4'h0); step();
      chk("rep_pend_no_start", {60'h0, bus.o_ch_start}, 64'h0);
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h1); step();
      chk("rep_pend_start", {60'h0, bus.o_ch_start}, 64'h1);
      chk("rep_pend_busy", {60'h0, bus.o_ch_busy}, 64'h1);
      chk("rep_pend_pat", {32'h0, opat(0)}, {32'h0, 32'hCAFE0002});
      drive(1, 0, 1, 0, 1, 32'hCAFE0003, 32'h3, 4'h0); step();
      drive(1, 0, 0, 1, 0, 32'h0, 32'h0, 4'h0); step();
      chk("stop_ctrl", {46'h0, ctrl()}, {46'h0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0});
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h1); step();
      chk("done_on_idle", {46'h0, ctrl()}, {46'h0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0});
      chk("done_on_idle_pat", {32'h0, opat(0)}, {32'h0, 32'hCAFE0002});
      idle_in();

      // Asynchronous reset mid-cycle clears everything before the next edge.
      drive(1, 1, 1, 0, 1, 32'h12345678, 32'h9, 4'h0); step();
      idle_in();
      chk("pre_areset_busy", {60'h0, bus.o_ch_busy}, 64'h2);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_ctrl", {46'h0, ctrl()}, 64'h0);
      chk("areset_pat", {32'h0, opat(1)}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Broadcast select with every channel idle.
      drive(1, 15, 1, 0, 0, 32'h0F0F0F0F, 32'hF, 4'h0); step();
      idle_in();
`ifdef SERIAL_SYNC_START_EN
      chk("bcast_idle", {46'h0, ctrl()}, {46'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0});
      chk("bcast_pat3", {32'h0, opat(3)}, {32'h0, 32'h0F0F0F0F});
`else
      chk("bcast_idle", {46'h0, ctrl()}, {46'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1});
      chk("bcast_pat3", {32'h0, opat(3)}, 64'h0);
`endif
      step();
      chk("tick_one_cycle", {46'h0, ctrl()} & 64'h3C003, 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
